// File: rtl/mult_serial_host_pkg.sv
// Shared types and constants for the serial multiplier host.
// Holds the FSM encoding, operand/product widths and default gap length.
package mult_serial_host_pkg;

   localparam int OPW          = 16;
   localparam int PW           = 32;
   localparam int WAIT_CYC_DEF = 2;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      GAP,
      CAPTURE,
      DONE
   } state_t;

   function automatic logic [PW-1:0] abs_diff(
      input logic [PW-1:0] x,
      input logic [PW-1:0] y
   );
      return (x >= y) ? (x - y) : (y - x);
   endfunction

endpackage

// File: rtl/mult_serial_host_if.sv
// Host-side request/result bundle of the serial multiplier host.
// The host drives start/operands; the block returns product and error.
interface mult_serial_host_if;
   import mult_serial_host_pkg::*;

   logic           start;
   logic [OPW-1:0] op_a;
   logic [OPW-1:0] op_b;
   logic           ready;
   logic [PW-1:0]  result;
   logic           result_valid;
   logic [PW-1:0]  err_dist;
   logic           err_nonzero;

   modport master (
      output start, op_a, op_b,
      input  ready, result, result_valid, err_dist, err_nonzero
   );

   modport slave (
      input  start, op_a, op_b,
      output ready, result, result_valid, err_dist, err_nonzero
   );

endinterface

// File: rtl/mult_serial_capture.sv
// Deserializer for the P0/P1 product streams.
// Sample j lands in result[j] (P0) and result[j+16] (P1).
module mult_serial_capture
   import mult_serial_host_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic          p0,
   input  logic          p1,
   output logic          last,
   output logic [PW-1:0] result
);

   logic [3:0] cnt;

   // the 16th sample is the one taken with cnt at 15; cnt then wraps to 0
   assign last = en && (cnt == 4'd15);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= 4'd0;
         result <= '0;
      end else if (clr) begin
         cnt    <= 4'd0;
         result <= '0;
      end else if (en) begin
         result[{1'b0, cnt}] <= p0;
         result[{1'b1, cnt}] <= p1;
         cnt                 <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/mult_serial_host.sv
// Host for an external bit-serial multiplier: serializes operands,
// waits the device latency, deserializes the product and scores its error.
module mult_serial_host
   import mult_serial_host_pkg::*;
#(
   parameter int WAIT_CYC = WAIT_CYC_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_serial_host_if.slave    bus,
   output logic                 A_PAD,
   output logic                 B_PAD,
   output logic                 PAD_LOAD,
   input  logic                 P0,
   input  logic                 P1
);

   localparam logic [3:0] GAP_LOAD =
      (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

   state_t          state;
   logic [OPW-1:0]  a_q;
   logic [OPW-1:0]  b_q;
   logic [3:0]      bit_cnt;
   logic [3:0]      gap_cnt;
   logic            ready_q;
   logic            rv_q;
   logic [PW-1:0]   err_q;
   logic            errnz_q;
   logic [PW-1:0]   prod;
   logic [PW-1:0]   cap_result;
   logic            cap_last;
   logic            accept;
   logic            cap_en;

   assign accept = (state == IDLE) && bus.start;
   assign cap_en = (state == CAPTURE);
   assign prod   = {16'b0, a_q} * {16'b0, b_q};

   assign bus.ready        = ready_q;
   assign bus.result       = cap_result;
   assign bus.result_valid = rv_q;
   assign bus.err_dist     = err_q;
   assign bus.err_nonzero  = errnz_q;

   mult_serial_capture u_capture (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (cap_en),
      .p0     (P0),
      .p1     (P1),
      .last   (cap_last),
      .result (cap_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ready_q  <= 1'b1;
         A_PAD    <= 1'b0;
         B_PAD    <= 1'b0;
         PAD_LOAD <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         bit_cnt  <= 4'd0;
         gap_cnt  <= 4'd0;
         rv_q     <= 1'b0;
         err_q    <= '0;
         errnz_q  <= 1'b0;
      end else begin
         rv_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q      <= bus.op_a;
                  b_q      <= bus.op_b;
                  A_PAD    <= bus.op_a[0];
                  B_PAD    <= bus.op_b[0];
                  PAD_LOAD <= 1'b1;
                  bit_cnt  <= 4'd1;
                  ready_q  <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               // bit_cnt wraps to 0 once bit 15 has been driven
               if (bit_cnt == 4'd0) begin
                  A_PAD    <= 1'b0;
                  B_PAD    <= 1'b0;
                  PAD_LOAD <= 1'b0;
                  if (WAIT_CYC == 0) begin
                     state <= CAPTURE;
                  end else begin
                     gap_cnt <= GAP_LOAD;
                     state   <= GAP;
                  end
               end else begin
                  A_PAD   <= a_q[bit_cnt];
                  B_PAD   <= b_q[bit_cnt];
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
            GAP: begin
               if (gap_cnt == 4'd0) begin
                  state <= CAPTURE;
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            CAPTURE: begin
               if (cap_last) begin
                  state <= DONE;
               end
            end
            DONE: begin
               err_q   <= abs_diff(prod, cap_result);
               errnz_q <= (prod != cap_result);
               rv_q    <= 1'b1;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
